dram_stream_reader: RTL and testbench

Read-side engine for the trace/monitoring dual-port RAM. On a start command it walks a contiguous address range on one RAM port, absorbs the RAM's one-cycle registered read latency, and presents the words on a valid/ready stream toward the host export path. It sits between the trace RAM's second port and the host-facing output stream. It never stalls the writer on the other RAM port.

---
 rtl/dram_stream_reader_pkg.sv | 12 +
 rtl/dram_stream_reader_fifo.sv | 57 +++++
 rtl/dram_stream_reader.sv | 139 +++++++++++++
 tb/tb_dram_stream_reader.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_stream_reader_pkg.sv
// Shared types for the trace-RAM stream reader: FSM state encoding and output FIFO depth.
package dram_stream_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/dram_stream_reader_fifo.sv
// Two-entry synchronous FIFO carrying a data word plus its end-of-command flag.
module dram_reader_fifo
    import dram_stream_reader_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             push_last_i,
    input  logic             pop_i,
    output logic [1:0]       count_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             last_o
);

    localparam logic [1:0] DEPTH_C = 2'(FIFO_DEPTH);

    logic [WIDTH:0] mem_q [FIFO_DEPTH];
    logic           wr_ptr_q;
    logic           rd_ptr_q;
    logic [1:0]     count_q;
    logic           do_push;
    logic           do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push_i && ((count_q != DEPTH_C) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= {push_last_i, push_data_i};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign count_o = count_q;
    assign valid_o = (count_q != 2'd0);
    assign data_o  = mem_q[rd_ptr_q][WIDTH-1:0];
    assign last_o  = mem_q[rd_ptr_q][WIDTH];

endmodule

// File: rtl/dram_stream_reader.sv
// Walks an address range on the trace RAM read port and streams the words out over valid/ready.
// Optional clear-on-read (each read followed by a zero write) is enabled by DRAM_READER_CLEAR_EN.
module dram_stream_reader
    import dram_stream_reader_pkg::*;
#(
    parameter int WORD_SIZE = 64,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_SIZE-1:0] start_address,
    input  logic [ADDR_SIZE:0]   word_count,
    output logic                 busy,
    output logic                 done,
    output logic                 ram_write_enable,
    output logic [ADDR_SIZE-1:0] ram_address,
    output logic [WORD_SIZE-1:0] ram_data_in,
    input  logic [WORD_SIZE-1:0] ram_output,
    output logic [WORD_SIZE-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last
);

    localparam logic [ADDR_SIZE:0] REM_ONE = (ADDR_SIZE+1)'(1);

    state_e               state_q, state_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [ADDR_SIZE:0]   remaining_q, remaining_d;
    logic                 inflight_q;
    logic                 inflight_last_q;
    logic [1:0]           fifo_count;
    logic                 pop;
    logic                 credit_ok;
    logic                 issue;

    // Valid/ready: a word transfers in any cycle where out_valid and out_ready are both high;
    // out_data/out_last are held stable from the first valid cycle until that transfer.
    assign pop       = out_valid & out_ready;
    assign credit_ok = ({1'b0, fifo_count} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});

`ifdef DRAM_READER_CLEAR_EN
    logic [ADDR_SIZE-1:0] last_addr_q;

    // The cycle after a read belongs to its clear write, so no read may issue then.
    assign issue = (state_q == READ) && (remaining_q != '0) && credit_ok && !inflight_q;
`else
    assign issue = (state_q == READ) && (remaining_q != '0) && credit_ok;
`endif

    assign busy        = (state_q != IDLE);
    assign ram_data_in = '0;

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        remaining_d      = remaining_q;
        done             = 1'b0;
        ram_write_enable = 1'b0;
        ram_address      = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d      = start_address;
                    remaining_d = word_count;
                    state_d     = (word_count == '0) ? DRAIN : READ;
                end
            end
            READ: begin
                if (issue) begin
                    ram_address = addr_q;
                    addr_d      = addr_q + ADDR_SIZE'(1);
                    remaining_d = remaining_q - REM_ONE;
                    if (remaining_q == REM_ONE) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((fifo_count == 2'd0) && !inflight_q) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef DRAM_READER_CLEAR_EN
        if (inflight_q) begin
            ram_write_enable = 1'b1;
            ram_address      = last_addr_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            remaining_q     <= remaining_d;
            inflight_q      <= issue;
            inflight_last_q <= issue && (remaining_q == REM_ONE);
        end
    end

`ifdef DRAM_READER_CLEAR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_addr_q <= '0;
        end else if (issue) begin
            last_addr_q <= addr_q;
        end
    end
`endif

    dram_reader_fifo #(
        .WIDTH(WORD_SIZE)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (inflight_q),
        .push_data_i(ram_output),
        .push_last_i(inflight_last_q),
        .pop_i      (pop),
        .count_o    (fifo_count),
        .valid_o    (out_valid),
        .data_o     (out_data),
        .last_o     (out_last)
    );

endmodule

// File: tb/tb_dram_stream_reader.sv
// Scoreboarded bench for dram_stream_reader with a behavioural write-through RAM on its port.
module tb_dram_stream_reader;

    localparam int W = 64;
    localparam int A = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [A-1:0] start_address = '0;
    logic [A:0]   word_count = '0;
    logic         busy;
    logic         done;
    logic         ram_write_enable;
    logic [A-1:0] ram_address;
    logic [W-1:0] ram_data_in;
    logic [W-1:0] ram_output;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         out_last;

    logic [W-1:0] ram     [256];
    logic [W-1:0] ref_mem [256];
    logic [W:0]   exp_q [$];

    int errors = 0;
    int checks = 0;

    int r_done, r_first, r_last, r_words, r_reads, r_valid, r_we, r_max_fifo;

    dram_stream_reader #(
        .WORD_SIZE(W),
        .ADDR_SIZE(A)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .start_address   (start_address),
        .word_count      (word_count),
        .busy            (busy),
        .done            (done),
        .ram_write_enable(ram_write_enable),
        .ram_address     (ram_address),
        .ram_data_in     (ram_data_in),
        .ram_output      (ram_output),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_last        (out_last)
    );

    // Clock and RAM model (registered read, write-through on write)
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_write_enable) begin
            ram[ram_address] <= ram_data_in;
        end
        ram_output <= ram_write_enable ? ram_data_in : ram[ram_address];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    // Driver + monitor: issues one command, pops the scoreboard on every handshake.
    task automatic run_stream(input logic [A-1:0] a, input int n, input int mode,
                              input int stop_after, input int poke);
        int         c;
        logic       held;
        logic [W:0] held_v;
        logic [W:0] e;
        @(posedge clk); #1;
        start         = 1'b1;
        start_address = a;
        word_count    = (A+1)'(n);
        out_ready     = 1'b1;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({(i == n - 1), ref_mem[(int'(a) + i) % 256]});
        end
        r_done = -1; r_first = -1; r_last = -1; r_words = 0;
        r_reads = 0; r_valid = 0; r_we = 0; r_max_fifo = 0;
        c = 0;
        held = 1'b0;
        held_v = '0;
        while (c < 300) begin
            @(negedge clk);
            if (dut.issue) r_reads++;
            if (ram_write_enable) r_we++;
            if (int'(dut.fifo_count) > r_max_fifo) r_max_fifo = int'(dut.fifo_count);
            if (out_valid) r_valid++;
            if (held) begin
                checks++;
                if (out_valid !== 1'b1 || {out_last, out_data} !== held_v) begin
                    errors++;
                    $display("FAIL hold_stable cyc=%0d got valid=%0b %h want valid=1 %h",
                             c, out_valid, {out_last, out_data}, held_v);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_word cyc=%0d got %h want none", c, {out_last, out_data});
                end else begin
                    e = exp_q.pop_front();
                    if ({out_last, out_data} !== e) begin
                        errors++;
                        $display("FAIL stream_word cyc=%0d got %h want %h", c, {out_last, out_data}, e);
                    end
                end
                if (r_first < 0) r_first = c;
                r_last = c;
                r_words++;
                held = 1'b0;
            end else if (out_valid) begin
                held   = 1'b1;
                held_v = {out_last, out_data};
            end
            if (done === 1'b1) begin
                r_done = c;
                break;
            end
            if (stop_after >= 0 && r_words >= stop_after) break;
            @(posedge clk); #1;
            start = 1'b0;
            c++;
            if (mode == 1) out_ready = ~out_ready;
            if (c == poke) begin
                start         = 1'b1;
                start_address = 8'h80;
                word_count    = 9'd3;
            end
        end
        start = 1'b0;
        if (stop_after < 0) begin
            checks++;
            if (r_done < 0) begin
                errors++;
                $display("FAIL done_timeout got no done want done within 300 cycles");
            end
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL missing_words got %0d left want 0", exp_q.size());
            end
            exp_q.delete();
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if ({busy, done, out_valid, out_last, ram_write_enable} !== 5'b0 ||
            out_data !== '0 || ram_address !== '0 || ram_data_in !== '0) begin
            errors++;
            $display("FAIL %s got busy=%0b done=%0b valid=%0b last=%0b we=%0b data=%h addr=%h din=%h want all 0",
                     tag, busy, done, out_valid, out_last, ram_write_enable, out_data, ram_address, ram_data_in);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        check_idle_outputs("reset_values");
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int exp_last, exp_done;
`ifdef DRAM_READER_CLEAR_EN
        exp_last = 7; exp_done = 8;
`else
        exp_last = 5; exp_done = 6;
`endif
        run_stream(8'h04, 3, 0, -1, -1);
        checks++;
        if (r_words != 3 || r_reads != 3) begin
            errors++;
            $display("FAIL basic_count got words=%0d reads=%0d want 3 3", r_words, r_reads);
        end
        checks++;
        if (r_first != 3 || r_last != exp_last || r_done != exp_done) begin
            errors++;
            $display("FAIL basic_timing got first=%0d last=%0d done=%0d want 3 %0d %0d",
                     r_first, r_last, r_done, exp_last, exp_done);
        end
`ifndef DRAM_READER_CLEAR_EN
        checks++;
        if (r_we != 0) begin
            errors++;
            $display("FAIL basic_no_write got we_cycles=%0d want 0", r_we);
        end
`endif
    endtask

    task automatic test_wrap();
        run_stream(8'hFE, 4, 0, -1, -1);
        checks++;
        if (r_words != 4) begin
            errors++;
            $display("FAIL wrap_count got %0d want 4", r_words);
        end
    endtask

    task automatic test_backpressure();
        run_stream(8'h10, 8, 1, -1, -1);
        checks++;
        if (r_words != 8 || r_reads != 8) begin
            errors++;
            $display("FAIL bp_count got words=%0d reads=%0d want 8 8", r_words, r_reads);
        end
        checks++;
        if (r_max_fifo > 2) begin
            errors++;
            $display("FAIL bp_fifo_level got max=%0d want <=2", r_max_fifo);
        end
    endtask

    task automatic test_zero_count();
        run_stream(8'h33, 0, 0, -1, -1);
        checks++;
        if (r_done != 1 || r_valid != 0 || r_reads != 0 || r_we != 0) begin
            errors++;
            $display("FAIL zero_count got done=%0d valid=%0d reads=%0d we=%0d want 1 0 0 0",
                     r_done, r_valid, r_reads, r_we);
        end
    endtask

    task automatic test_start_while_busy();
        int exp_done;
`ifdef DRAM_READER_CLEAR_EN
        exp_done = 14;
`else
        exp_done = 9;
`endif
        run_stream(8'h20, 6, 0, -1, 2);
        checks++;
        if (r_words != 6 || r_reads != 6 || r_done != exp_done) begin
            errors++;
            $display("FAIL busy_start got words=%0d reads=%0d done=%0d want 6 6 %0d",
                     r_words, r_reads, r_done, exp_done);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_after got busy=%0b valid=%0b want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        run_stream(8'h30, 8, 0, 2, -1);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("reset_mid_outputs");
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        test_basic();
    endtask

    task automatic test_reread();
        run_stream(8'h50, 4, 0, -1, -1);
        checks++;
        if (r_words != 4) begin
            errors++;
            $display("FAIL reread_first got %0d want 4", r_words);
        end
`ifdef DRAM_READER_CLEAR_EN
        checks++;
        if (r_we != 4 || (r_last - r_first) != 6) begin
            errors++;
            $display("FAIL clear_spacing got we=%0d span=%0d want 4 6", r_we, r_last - r_first);
        end
        for (int i = 0; i < 4; i++) ref_mem[16'h50 + i] = '0;
`endif
        run_stream(8'h50, 4, 0, -1, -1);
        checks++;
        if (r_words != 4) begin
            errors++;
            $display("FAIL reread_second got %0d want 4", r_words);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]     <= 64'(i) + 64'h100;
            ref_mem[i]  = 64'(i) + 64'h100;
        end
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_count();
        test_start_while_busy();
        test_reset_mid();
        test_reread();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
